// File: rtl/dst_reg_pipe_pkg.sv
// Shared CPU definitions for destination-register tracking: destination-select
// encodings, default link register and forwarding-select width.
package dst_reg_pipe_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } dst_sel_e;

  localparam int LINK_REG_DEFAULT = 31;
  localparam int FWD_W            = 4;
  localparam int MIN_STAGES       = 2;
  localparam int MAX_STAGES       = 8;

endpackage

// File: rtl/dst_reg_pipe_if.sv
// Decode-side bundle of the destination-register pipe: entering instruction,
// pipeline control, source registers, and the write-back/forwarding results.
interface dst_reg_pipe_if #(
  parameter int BITS_REGS = 5
);
  import dst_reg_pipe_pkg::*;

  logic                 i_valid;
  dst_sel_e             i_dst_sel;
  logic [BITS_REGS-1:0] i_rt;
  logic [BITS_REGS-1:0] i_rd;
  logic                 i_reg_write;
  logic                 i_stall;
  logic                 i_flush;
  logic [BITS_REGS-1:0] i_src_a;
  logic [BITS_REGS-1:0] i_src_b;
  logic [BITS_REGS-1:0] o_wb_addr;
  logic                 o_wb_we;
  logic [FWD_W-1:0]     o_fwd_a;
  logic [FWD_W-1:0]     o_fwd_b;
  logic                 o_link_pending;

  modport master (
    output i_valid, i_dst_sel, i_rt, i_rd, i_reg_write,
    output i_stall, i_flush, i_src_a, i_src_b,
    input  o_wb_addr, o_wb_we, o_fwd_a, o_fwd_b, o_link_pending
  );

  modport slave (
    input  i_valid, i_dst_sel, i_rt, i_rd, i_reg_write,
    input  i_stall, i_flush, i_src_a, i_src_b,
    output o_wb_addr, o_wb_we, o_fwd_a, o_fwd_b, o_link_pending
  );

endinterface

// File: rtl/dst_match_enc.sv
// Compares one source register against every in-flight destination and
// returns the youngest matching stage index plus one (0 = no match).
module dst_match_enc
  import dst_reg_pipe_pkg::*;
#(
  parameter int BITS_REGS = 5,
  parameter int STAGES    = 3
) (
  input  logic [STAGES-1:0][BITS_REGS-1:0] stg_addr,
  input  logic [STAGES-1:0]                stg_vld,
  input  logic [BITS_REGS-1:0]             src,
  output logic [FWD_W-1:0]                 fwd
);

  logic [STAGES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit[k] = stg_vld[k] && (stg_addr[k] == src) && (src != '0);
    end
  end

  // Walk oldest to youngest so the lowest matching index is the last written.
  always_comb begin
    fwd = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        fwd = FWD_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/dst_reg_pipe.sv
// Tracks the destination register of each in-flight instruction from EX to WB
// and derives write-back, operand-forwarding selects and a pending-link flag.
module dst_reg_pipe
  import dst_reg_pipe_pkg::*;
#(
  parameter int BITS_REGS = 5,
  parameter int STAGES    = 3,
  parameter int LINK_REG  = LINK_REG_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  dst_reg_pipe_if.slave bus
);

  localparam logic [BITS_REGS-1:0] LINK_ADDR = BITS_REGS'(LINK_REG);

  logic [BITS_REGS-1:0]             entry_addr;
  logic                             entry_vld;
  logic [STAGES-1:0][BITS_REGS-1:0] addr_p;
  logic [STAGES-1:0]                vld_p;
  logic [STAGES-1:0]                link_hit;

  // Entry: destination select and write qualification (r0 is never written).
  always_comb begin
    entry_addr = bus.i_rt;
    unique case (bus.i_dst_sel)
      DST_RT:   entry_addr = bus.i_rt;
      DST_RD:   entry_addr = bus.i_rd;
      DST_LINK: entry_addr = LINK_ADDR;
      DST_NONE: entry_addr = bus.i_rt;
      default:  entry_addr = bus.i_rt;
    endcase
  end

  assign entry_vld = bus.i_valid && bus.i_reg_write &&
                     (bus.i_dst_sel != DST_NONE) && (entry_addr != '0);

  // Stage 0 .. STAGES-1: shift on advance; flush clears stage 0 even when stalled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_p <= '0;
      vld_p  <= '0;
    end else if (!bus.i_stall) begin
      addr_p[0] <= entry_addr;
      vld_p[0]  <= entry_vld && !bus.i_flush;
      for (int k = 1; k < STAGES; k++) begin
        addr_p[k] <= addr_p[k-1];
        vld_p[k]  <= vld_p[k-1];
      end
    end else if (bus.i_flush) begin
      vld_p[0] <= 1'b0;
    end
  end

  // Write-back: address is forced to 0 when the last stage carries no write.
  assign bus.o_wb_we   = vld_p[STAGES-1];
  assign bus.o_wb_addr = vld_p[STAGES-1] ? addr_p[STAGES-1] : '0;

  always_comb begin
    link_hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      link_hit[k] = vld_p[k] && (addr_p[k] == LINK_ADDR);
    end
  end

  assign bus.o_link_pending = |link_hit;

  dst_match_enc #(
    .BITS_REGS (BITS_REGS),
    .STAGES    (STAGES)
  ) u_match_a (
    .stg_addr (addr_p),
    .stg_vld  (vld_p),
    .src      (bus.i_src_a),
    .fwd      (bus.o_fwd_a)
  );

  dst_match_enc #(
    .BITS_REGS (BITS_REGS),
    .STAGES    (STAGES)
  ) u_match_b (
    .stg_addr (addr_p),
    .stg_vld  (vld_p),
    .src      (bus.i_src_b),
    .fwd      (bus.o_fwd_b)
  );

endmodule

// File: tb/tb_dst_reg_pipe.sv
// Directed bench for dst_reg_pipe: latency, link, forwarding priority,
// stall/flush and asynchronous reset behaviour with STAGES=3.
module tb_dst_reg_pipe;
  import dst_reg_pipe_pkg::*;

  localparam int BITS_REGS = 5;
  localparam int STAGES    = 3;
  localparam int LINK_REG  = 31;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dst_reg_pipe_if #(.BITS_REGS(BITS_REGS)) bus ();

  dst_reg_pipe #(
    .BITS_REGS (BITS_REGS),
    .STAGES    (STAGES),
    .LINK_REG  (LINK_REG)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input dst_sel_e sel, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw);
    bus.i_valid     = vld;
    bus.i_dst_sel   = sel;
    bus.i_rt        = rt;
    bus.i_rd        = rd;
    bus.i_reg_write = rw;
  endtask

  task automatic idle();
    drive(1'b0, DST_NONE, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic src(input logic [4:0] a, input logic [4:0] b);
    bus.i_src_a = a;
    bus.i_src_b = b;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_src_a = 5'd0;
    bus.i_src_b = 5'd0;
    #2;
    chk("rst_wb_we",   32'(bus.o_wb_we), 0);
    chk("rst_wb_addr", 32'(bus.o_wb_addr), 0);
    chk("rst_fwd_a",   32'(bus.o_fwd_a), 0);
    chk("rst_fwd_b",   32'(bus.o_fwd_b), 0);
    chk("rst_link",    32'(bus.o_link_pending), 0);
    step();
    rst_n = 1'b1;

    // Latency: rd=7 written at edge 1 appears after edge 3.
    drive(1'b1, DST_RD, 5'd3, 5'd7, 1'b1);
    step();
    idle();
    src(5'd7, 5'd3);
    chk("lat_e1_we", 32'(bus.o_wb_we), 0);
    chk("lat_e1_fa", 32'(bus.o_fwd_a), 1);
    chk("lat_e1_fb", 32'(bus.o_fwd_b), 0);
    step();
    chk("lat_e2_we", 32'(bus.o_wb_we), 0);
    chk("lat_e2_fa", 32'(bus.o_fwd_a), 2);
    step();
    chk("lat_e3_we",   32'(bus.o_wb_we), 1);
    chk("lat_e3_addr", 32'(bus.o_wb_addr), 7);
    chk("lat_e3_fa",   32'(bus.o_fwd_a), 3);
    step();
    chk("lat_e4_we", 32'(bus.o_wb_we), 0);
    chk("lat_e4_fa", 32'(bus.o_fwd_a), 0);

    // JAL to the link register.
    drive(1'b1, DST_LINK, 5'd2, 5'd4, 1'b1);
    step();
    idle();
    chk("jal_pend1", 32'(bus.o_link_pending), 1);
    chk("jal_we1",   32'(bus.o_wb_we), 0);
    step();
    step();
    chk("jal_wb_we",   32'(bus.o_wb_we), 1);
    chk("jal_wb_addr", 32'(bus.o_wb_addr), 31);
    chk("jal_pend3",   32'(bus.o_link_pending), 1);
    step();
    chk("jal_pend4", 32'(bus.o_link_pending), 0);

    // Writes to r0 never qualify.
    drive(1'b1, DST_RD, 5'd6, 5'd0, 1'b1);
    step();
    idle();
    src(5'd0, 5'd6);
    chk("r0_fa", 32'(bus.o_fwd_a), 0);
    chk("r0_fb", 32'(bus.o_fwd_b), 0);
    step();
    step();
    chk("r0_wb_we", 32'(bus.o_wb_we), 0);
    step();
    chk("r0_wb_we2", 32'(bus.o_wb_we), 0);

    // Youngest-first priority: stages hold 9,4,9.
    drive(1'b1, DST_RT, 5'd9, 5'd1, 1'b1);
    step();
    drive(1'b1, DST_RD, 5'd1, 5'd4, 1'b1);
    step();
    drive(1'b1, DST_RD, 5'd2, 5'd9, 1'b1);
    step();
    idle();
    src(5'd9, 5'd4);
    chk("pri_fa9", 32'(bus.o_fwd_a), 1);
    chk("pri_fb4", 32'(bus.o_fwd_b), 2);
    src(5'd5, 5'd0);
    chk("pri_fa5", 32'(bus.o_fwd_a), 0);
    chk("pri_fb0", 32'(bus.o_fwd_b), 0);
    drive(1'b1, DST_NONE, 5'd9, 5'd9, 1'b1);
    step();
    idle();
    src(5'd9, 5'd4);
    chk("pri_none_fa", 32'(bus.o_fwd_a), 2);
    chk("pri_none_fb", 32'(bus.o_fwd_b), 3);
    step();
    step();

    // Two stall cycles add two cycles of latency.
    drive(1'b1, DST_RD, 5'd1, 5'd12, 1'b1);
    step();
    idle();
    bus.i_stall = 1'b1;
    src(5'd12, 5'd0);
    step();
    chk("stl1_fa", 32'(bus.o_fwd_a), 1);
    drive(1'b1, DST_RD, 5'd1, 5'd13, 1'b1);
    step();
    idle();
    src(5'd12, 5'd13);
    chk("stl2_fa", 32'(bus.o_fwd_a), 1);
    chk("stl2_fb", 32'(bus.o_fwd_b), 0);
    chk("stl2_we", 32'(bus.o_wb_we), 0);
    bus.i_stall = 1'b0;
    step();
    chk("stl3_fa", 32'(bus.o_fwd_a), 2);
    chk("stl3_we", 32'(bus.o_wb_we), 0);
    step();
    chk("stl4_we",   32'(bus.o_wb_we), 1);
    chk("stl4_addr", 32'(bus.o_wb_addr), 12);
    step();

    // Stall with flush: stage 0 squashed, stage 1 held.
    drive(1'b1, DST_RD, 5'd1, 5'd21, 1'b1);
    step();
    drive(1'b1, DST_RD, 5'd1, 5'd20, 1'b1);
    step();
    drive(1'b1, DST_RD, 5'd1, 5'd25, 1'b1);
    bus.i_stall = 1'b1;
    bus.i_flush = 1'b1;
    step();
    idle();
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    src(5'd20, 5'd21);
    chk("sf_fa20", 32'(bus.o_fwd_a), 0);
    chk("sf_fb21", 32'(bus.o_fwd_b), 2);
    src(5'd25, 5'd0);
    chk("sf_fa25", 32'(bus.o_fwd_a), 0);
    step();
    chk("sf_wb_we",   32'(bus.o_wb_we), 1);
    chk("sf_wb_addr", 32'(bus.o_wb_addr), 21);
    step();
    chk("sf_wb_we2", 32'(bus.o_wb_we), 0);

    // Flush without stall drops the entering instruction.
    drive(1'b1, DST_RD, 5'd1, 5'd22, 1'b1);
    bus.i_flush = 1'b1;
    step();
    idle();
    bus.i_flush = 1'b0;
    src(5'd22, 5'd0);
    chk("fl_fa22", 32'(bus.o_fwd_a), 0);
    step();
    step();
    chk("fl_wb_we", 32'(bus.o_wb_we), 0);

    // Reset mid-run with three writes in flight.
    drive(1'b1, DST_RD, 5'd1, 5'd10, 1'b1);
    step();
    drive(1'b1, DST_LINK, 5'd1, 5'd1, 1'b1);
    step();
    drive(1'b1, DST_RD, 5'd1, 5'd11, 1'b1);
    step();
    idle();
    src(5'd11, 5'd10);
    chk("pre_rst_link", 32'(bus.o_link_pending), 1);
    chk("pre_rst_fa",   32'(bus.o_fwd_a), 1);
    chk("pre_rst_we",   32'(bus.o_wb_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_we",   32'(bus.o_wb_we), 0);
    chk("mrst_addr", 32'(bus.o_wb_addr), 0);
    chk("mrst_fa",   32'(bus.o_fwd_a), 0);
    chk("mrst_fb",   32'(bus.o_fwd_b), 0);
    chk("mrst_link", 32'(bus.o_link_pending), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < STAGES + 1; i++) begin
      step();
      chk("post_rst_we",   32'(bus.o_wb_we), 0);
      chk("post_rst_link", 32'(bus.o_link_pending), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
